// File: rtl/datapath_arbiter.sv
// Round-robin arbiter sharing one start/finished datapath between requesters.
// Each requester sees a private-looking datapath handshake.
//
// Ports:
//   clock, resetn       : clock, asynchronous active-low reset
//   req_start           : per-requester start (bit i = requester i)
//   req_instruction     : per-requester instruction, slice i*INSTR_W
//   req_finished        : per-requester finished (registered, 1 = idle)
//   req_result          : per-requester result, slice i*RES_W (registered)
//   dp_start            : start to the shared datapath (2-cycle pulse)
//   dp_instruction      : instruction to the shared datapath
//   dp_finished         : datapath finished flag
//   dp_result           : datapath result
//   busy                : high while an operation is in flight
//   grant_id            : requester currently being served
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif
`ifndef RESULT_WIDTH
`define RESULT_WIDTH 16
`endif

module datapath_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int INSTR_W = `INSTRUCTION_WIDTH,
    parameter int RES_W   = `RESULT_WIDTH
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req_start,
    input  logic [NUM_REQ*INSTR_W-1:0] req_instruction,
    output logic [NUM_REQ-1:0]         req_finished,
    output logic [NUM_REQ*RES_W-1:0]   req_result,
    output logic                       dp_start,
    output logic [INSTR_W-1:0]         dp_instruction,
    input  logic                       dp_finished,
    input  logic [RES_W-1:0]           dp_result,
    output logic                       busy,
    output logic [ID_W-1:0]            grant_id
);

    localparam int NSLOT = 1 << ID_W;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD,
        WAIT
    } state_t;

    state_t                   state_q;
    logic [NUM_REQ-1:0]       pend_q;
    logic [ID_W-1:0]          rr_q;
    logic [ID_W-1:0]          grant_q;
    logic [NUM_REQ-1:0]       fin_q;
    logic [NUM_REQ*RES_W-1:0] res_q;
    logic                     dp_start_q;
    logic [INSTR_W-1:0]       dp_instr_q;
    logic                     busy_q;
    logic [INSTR_W-1:0]       ibuf_q [NUM_REQ];

    // Pending vector padded to the full ID space so an ID_W-bit index is
    // always in range.
    logic [NSLOT-1:0] pend_pad;
    logic [ID_W:0]    cand;
    logic [ID_W-1:0]  grant_d;
    logic             found;

    assign pend_pad = NSLOT'(pend_q);

    // First pending requester, searching circularly from rr_q.
    always_comb begin
        found   = 1'b0;
        grant_d = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!found && pend_pad[cand[ID_W-1:0]]) begin
                found   = 1'b1;
                grant_d = cand[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            rr_q       <= '0;
            grant_q    <= '0;
            fin_q      <= '1;
            res_q      <= '0;
            dp_start_q <= 1'b0;
            dp_instr_q <= '0;
            busy_q     <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                ibuf_q[i] <= '0;
            end
        end else begin
            // Capture runs in every state; a start seen while already
            // pending is a held or repeated pulse and is ignored.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_start[i] && !pend_q[i]) begin
                    pend_q[i] <= 1'b1;
                    fin_q[i]  <= 1'b0;
                    ibuf_q[i] <= req_instruction[i*INSTR_W +: INSTR_W];
                end
            end

            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_q    <= grant_d;
                        dp_instr_q <= ibuf_q[grant_d];
                        dp_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= HOLD;
                end
                HOLD: begin
                    dp_start_q <= 1'b0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    // Only a finished seen here belongs to this operation.
                    if (dp_finished) begin
                        for (int i = 0; i < NUM_REQ; i++) begin
                            if (ID_W'(i) == grant_q) begin
                                res_q[i*RES_W +: RES_W] <= dp_result;
                                fin_q[i]                <= 1'b1;
                                pend_q[i]               <= 1'b0;
                            end
                        end
                        rr_q    <= (grant_q == ID_W'(NUM_REQ-1)) ?
                                   '0 : grant_q + 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_finished   = fin_q;
    assign req_result     = res_q;
    assign dp_start       = dp_start_q;
    assign dp_instruction = dp_instr_q;
    assign busy           = busy_q;
    assign grant_id       = grant_q;

endmodule

// File: tb/tb_datapath_arbiter.sv
// Bench for datapath_arbiter: datapath stub, grant/completion scoreboard,
// directed scenarios.
module tb_datapath_arbiter;

    localparam int N  = 4;
    localparam int IW = 32;
    localparam int RW = 16;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic [N-1:0]  req_start = '0;
    logic [N*IW-1:0] req_instruction = '0;
    logic [N-1:0]  req_finished;
    logic [N*RW-1:0] req_result;
    logic          dp_start;
    logic [IW-1:0] dp_instruction;
    logic          dp_finished = 1'b0;
    logic [RW-1:0] dp_result = '0;
    logic          busy;
    logic [1:0]    grant_id;

    datapath_arbiter #(
        .NUM_REQ(N), .ID_W(2), .INSTR_W(IW), .RES_W(RW)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .req_start(req_start),
        .req_instruction(req_instruction),
        .req_finished(req_finished),
        .req_result(req_result),
        .dp_start(dp_start),
        .dp_instruction(dp_instruction),
        .dp_finished(dp_finished),
        .dp_result(dp_result),
        .busy(busy),
        .grant_id(grant_id)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] instr;
        logic [15:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   dp_lat = 5;
    bit   early_mode = 0;
    bit   mon_en = 0;

    function automatic logic [15:0] res_of(input logic [31:0] ins);
        return ins[15:0] ^ 16'h129F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input int id, input logic [31:0] ins);
        exp_t e;
        e.id = 2'(id);
        e.instr = ins;
        e.res = res_of(ins);
        exp_q.push_back(e);
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Datapath stub: after the 2-cycle start, waits, then pulses finished.
    // In early mode finished is already high during ISSUE/HOLD.
    initial begin
        forever begin
            @(negedge clock);
            if (resetn && dp_start) begin
                if (early_mode) dp_finished = 1'b1;
                @(negedge clock);
                @(negedge clock);
                dp_finished = 1'b0;
                repeat (dp_lat - 1) @(negedge clock);
                dp_result = res_of(dp_instruction);
                dp_finished = 1'b1;
                @(negedge clock);
                dp_finished = 1'b0;
            end
        end
    end

    // Monitor: checks each grant and completion against the scoreboard.
    initial begin
        logic [N-1:0] prev_fin;
        logic         prev_start;
        int           st_len;
        int           start_cyc;
        exp_t         e;
        prev_fin = '1;
        prev_start = 1'b0;
        st_len = 0;
        start_cyc = 0;
        forever begin
            @(negedge clock);
            if (!mon_en || !resetn) begin
                st_len = 0;
            end else begin
                if (dp_start) begin
                    if (!prev_start) begin
                        start_cyc = cyc;
                        chk("grant_expected", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) begin
                            chk("grant_id", grant_id, exp_q[0].id);
                            chk("dp_instruction", dp_instruction,
                                exp_q[0].instr);
                        end
                    end
                    st_len++;
                end else if (prev_start) begin
                    chk("dp_start_width", st_len, 2);
                    st_len = 0;
                end
                for (int i = 0; i < N; i++) begin
                    if (req_finished[i] && !prev_fin[i]) begin
                        chk("finish_expected", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            chk("finish_id", i, e.id);
                            chk("req_result", req_result[i*RW +: RW], e.res);
                            chk("finish_latency", cyc - start_cyc, 2 + dp_lat);
                        end
                    end
                end
            end
            prev_fin = req_finished;
            prev_start = dp_start;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        mon_en = 0;
        resetn = 1'b0;
        req_start = '0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        exp_q.delete();
        @(negedge clock);
        mon_en = 1;
    endtask

    task automatic pulse(input int i, input logic [31:0] ins);
        req_start[i] = 1'b1;
        req_instruction[i*IW +: IW] = ins;
        repeat (2) @(negedge clock);
        req_start[i] = 1'b0;
    endtask

    task automatic wait_fin(input int i);
        int c;
        c = 0;
        while (!req_finished[i] && c < 200) begin
            @(negedge clock);
            c++;
        end
        chk("finish_timeout", req_finished[i], 1);
    endtask

    initial begin
        // Reset state
        @(negedge clock);
        chk("rst_finished", req_finished, 4'hF);
        chk("rst_result_lo", req_result[31:0], 32'h0);
        chk("rst_result_hi", req_result[63:32], 32'h0);
        chk("rst_dp_start", dp_start, 0);
        chk("rst_dp_instr", dp_instruction, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        do_reset();

        // 1: single request
        push(1, 32'h1002_1234);
        req_start[1] = 1'b1;
        req_instruction[IW +: IW] = 32'h1002_1234;
        @(negedge clock);
        chk("t1_fin_fall", req_finished[1], 0);
        @(negedge clock);
        req_start[1] = 1'b0;
        wait_fin(1);
        chk("t1_result", req_result[RW +: RW], 16'h00AB);
        chk("t1_others_fin", {req_finished[3:2], req_finished[0]}, 3'b111);
        chk("t1_others_res0", req_result[0 +: RW], 0);
        chk("t1_others_res2", req_result[2*RW +: RW], 0);
        chk("t1_others_res3", req_result[3*RW +: RW], 0);

        // 2: simultaneous requests 0,1,3
        do_reset();
        push(0, 32'hA000_0001);
        push(1, 32'hB000_0022);
        push(3, 32'hC000_0333);
        req_instruction[0 +: IW] = 32'hA000_0001;
        req_instruction[IW +: IW] = 32'hB000_0022;
        req_instruction[3*IW +: IW] = 32'hC000_0333;
        req_start = 4'b1011;
        repeat (2) @(negedge clock);
        req_start = '0;
        wait_fin(0);
        chk("t2_busy_gap", busy, 0);
        @(negedge clock);
        chk("t2_busy_back", busy, 1);
        chk("t2_next_grant", grant_id, 1);
        wait_fin(1);
        wait_fin(3);
        chk("t2_res0", req_result[0 +: RW], res_of(32'hA000_0001));
        chk("t2_res1", req_result[RW +: RW], res_of(32'hB000_0022));
        chk("t2_res3", req_result[3*RW +: RW], res_of(32'hC000_0333));
        chk("t2_res2_untouched", req_result[2*RW +: RW], 0);
        chk("t2_drained", exp_q.size(), 0);

        // 3: fairness, grants 0,2,0,2
        do_reset();
        push(0, 32'h0000_1111);
        push(2, 32'h0000_2222);
        req_instruction[0 +: IW] = 32'h0000_1111;
        req_instruction[2*IW +: IW] = 32'h0000_2222;
        req_start = 4'b0101;
        repeat (2) @(negedge clock);
        req_start = '0;
        wait_fin(0);
        push(0, 32'h0000_3333);
        pulse(0, 32'h0000_3333);
        wait_fin(2);
        push(2, 32'h0000_4444);
        pulse(2, 32'h0000_4444);
        wait_fin(0);
        wait_fin(2);
        chk("t3_drained", exp_q.size(), 0);

        // 4: duplicate start while pending is ignored
        do_reset();
        push(0, 32'h5555_0000);
        push(2, 32'h6666_0606);
        req_instruction[0 +: IW] = 32'h5555_0000;
        req_instruction[2*IW +: IW] = 32'h6666_0606;
        req_start = 4'b0101;
        repeat (2) @(negedge clock);
        req_start = '0;
        pulse(2, 32'h7777_0707);
        wait_fin(0);
        wait_fin(2);
        repeat (30) @(negedge clock);
        chk("t4_one_completion", exp_q.size(), 0);
        chk("t4_fin2", req_finished[2], 1);
        chk("t4_busy", busy, 0);
        chk("t4_res2", req_result[2*RW +: RW], res_of(32'h6666_0606));

        // 5: finished high during ISSUE/HOLD is ignored
        do_reset();
        dp_lat = 4;
        early_mode = 1;
        push(1, 32'h0BAD_F00D);
        pulse(1, 32'h0BAD_F00D);
        chk("t5_no_early_fin", req_finished[1], 0);
        wait_fin(1);
        chk("t5_result", req_result[RW +: RW], res_of(32'h0BAD_F00D));
        repeat (5) @(negedge clock);
        early_mode = 0;
        dp_lat = 5;

        // 6: asynchronous reset while waiting on the datapath
        do_reset();
        push(1, 32'hDEAD_BEEF);
        pulse(1, 32'hDEAD_BEEF);
        @(negedge clock);
        chk("t6_in_wait", busy, 1);
        #2;
        mon_en = 0;
        resetn = 1'b0;
        #1;
        chk("t6_fin", req_finished, 4'hF);
        chk("t6_res", req_result[RW +: RW], 0);
        chk("t6_dp_start", dp_start, 0);
        chk("t6_dp_instr", dp_instruction, 0);
        chk("t6_busy", busy, 0);
        chk("t6_grant", grant_id, 0);
        exp_q.delete();
        @(negedge clock);
        resetn = 1'b1;
        repeat (15) @(negedge clock);
        chk("t6_no_result", req_result[RW +: RW], 0);
        chk("t6_fin_after", req_finished, 4'hF);
        chk("t6_pending_clear", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
